// File: rtl/decoder_pkg.sv
// Shared decode/branch types: machine word, branch kinds, and predictor
// counter/state types with the saturating counter update rule.
package decoder_pkg;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_JUMP = 2'b10,
    BR_JALR = 2'b11
  } branch_t;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

  // Unconditional jumps pin the counter to strongly-taken; otherwise saturate.
  function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken,
                                          input logic is_always);
    logic [1:0] raw;
    raw = ctr;
    if (is_always) begin
      raw = 2'b11;
    end else if (taken && (raw != 2'b11)) begin
      raw = raw + 2'b01;
    end else if (!taken && (raw != 2'b00)) begin
      raw = raw - 2'b01;
    end
    return bp_ctr_t'(raw);
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged target buffer: combinational read, synchronous write,
// and a clear port used by the predictor's post-reset walk.
module branch_target_buffer
  import decoder_pkg::*;
#(
  parameter int IDX_BITS = 4,
  localparam int TAG_BITS = 32 - IDX_BITS - 2,
  localparam int ENTRIES  = 1 << IDX_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  input  logic [TAG_BITS-1:0] rd_tag_i,
  output logic                rd_hit_o,
  output word                 rd_target_o,
  input  logic                wr_en_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0] wr_tag_i,
  input  word                 wr_target_i,
  input  logic                clr_en_i,
  input  logic [IDX_BITS-1:0] clr_idx_i
);

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  word                 target_q [ENTRIES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (clr_en_i) begin
      valid_q[clr_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/target payload needs no reset: it is only trusted behind a valid bit.
  always_ff @(posedge clk) begin
    if (!clr_en_i && wr_en_i) begin
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
    end
  end

  assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_target_o = target_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side bimodal predictor with BTB: clears its tables after reset, then
// predicts taken/target one cycle after fetch and learns from execute.
module branch_predictor
  import decoder_pkg::*;
#(
  parameter int         IDX_BITS  = 4,
  parameter logic [1:0] RESET_CTR = 2'b01
) (
  input  logic clk,
  input  logic reset_n,
  input  logic fetch_valid,
  input  word  fetch_pc,
  output logic pred_valid,
  output logic pred_taken,
  output word  pred_target,
  input  logic upd_valid,
  input  word  upd_pc,
  input  logic upd_taken,
  input  logic upd_always,
  input  word  upd_target,
  output logic init_done
);

  localparam int TAG_BITS = 32 - IDX_BITS - 2;
  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX = {IDX_BITS{1'b1}};

  bp_state_t           state_q;
  logic [IDX_BITS-1:0] clr_idx_q;
  logic                init_done_q;
  logic                pred_valid_q;
  logic                pred_taken_q, pred_taken_d;
  word                 pred_target_q, pred_target_d;
  bp_ctr_t             ctr_q [ENTRIES];

  logic [IDX_BITS-1:0] fetch_idx, upd_idx;
  logic [TAG_BITS-1:0] fetch_tag, upd_tag;
  logic                upd_en, btb_hit;
  word                 btb_target;
  logic                unused_low_bits;

  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign fetch_tag = fetch_pc[31:IDX_BITS+2];
  assign upd_idx   = upd_pc[IDX_BITS+1:2];
  assign upd_tag   = upd_pc[31:IDX_BITS+2];
  assign upd_en    = upd_valid && (state_q == RUN);
  assign unused_low_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      clr_idx_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == LAST_IDX) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: state_q <= RUN;
      endcase
    end
  end

  // Counters are untagged; aliased branches deliberately share one entry.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      ctr_q[clr_idx_q] <= bp_ctr_t'(RESET_CTR);
    end else if (upd_en) begin
      ctr_q[upd_idx] <= bp_ctr_next(ctr_q[upd_idx], upd_taken, upd_always);
    end
  end

  branch_target_buffer #(
    .IDX_BITS(IDX_BITS)
  ) u_btb (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_idx_i   (fetch_idx),
    .rd_tag_i   (fetch_tag),
    .rd_hit_o   (btb_hit),
    .rd_target_o(btb_target),
    .wr_en_i    (upd_en && upd_taken),
    .wr_idx_i   (upd_idx),
    .wr_tag_i   (upd_tag),
    .wr_target_i(upd_target),
    .clr_en_i   (state_q == INIT),
    .clr_idx_i  (clr_idx_q)
  );

  // Reads see pre-update table state, so a same-cycle update is not forwarded.
  always_comb begin
    pred_taken_d  = 1'b0;
    pred_target_d = pred_target_q;
    if (fetch_valid) begin
      pred_taken_d  = init_done_q && btb_hit && ctr_q[fetch_idx][1];
      pred_target_d = pred_taken_d ? btb_target : fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q  <= fetch_valid;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor: init walk, training, saturation,
// aliasing, same-cycle read/update ordering and asynchronous reset.
module tb_branch_predictor;

  logic        clk;
  logic        reset_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_always;
  logic [31:0] upd_target;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  branch_predictor dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fetch_valid(fetch_valid),
    .fetch_pc   (fetch_pc),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_always (upd_always),
    .upd_target (upd_target),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic always_j,
                        input logic [31:0] target);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_always = always_j;
    upd_target = target;
    tick();
    upd_valid  = 1'b0;
  endtask

  task automatic reset_and_init();
    reset_n     = 1'b0;
    fetch_valid = 1'b0;
    upd_valid   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    reset_n     = 1'b1;
    fetch_valid = 1'b0;
    fetch_pc    = '0;
    upd_valid   = 1'b0;
    upd_pc      = '0;
    upd_taken   = 1'b0;
    upd_always  = 1'b0;
    upd_target  = '0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (pred_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pred_valid: got %b expected 0", pred_valid); end
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_pred_taken: got %b expected 0", pred_taken); end
    checks++;
    if (pred_target !== 32'h0) begin errors++; $display("[TB] FAIL reset_pred_target: got %h expected 00000000", pred_target); end
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_done: got %b expected 0", init_done); end
    tick();
    tick();
  endtask

  task automatic test_init();
    reset_n = 1'b1;
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL init_done_c0: got %b expected 0", init_done); end
    fetch_valid = 1'b1;
    fetch_pc    = 32'h100;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) begin
        upd_valid  = 1'b1;
        upd_pc     = 32'h100;
        upd_taken  = 1'b1;
        upd_always = 1'b0;
        upd_target = 32'h80;
      end
      tick();
      upd_valid = 1'b0;
      checks++;
      if (init_done !== (k == 16)) begin errors++; $display("[TB] FAIL init_done_c%0d: got %b expected %b", k, init_done, (k == 16)); end
      checks++;
      if (pred_valid !== 1'b1) begin errors++; $display("[TB] FAIL init_pred_valid_c%0d: got %b expected 1", k, pred_valid); end
      checks++;
      if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL init_pred_taken_c%0d: got %b expected 0", k, pred_taken); end
      checks++;
      if (pred_target !== 32'h104) begin errors++; $display("[TB] FAIL init_pred_target_c%0d: got %h expected 00000104", k, pred_target); end
    end
    fetch_valid = 1'b0;
    fetch(32'h100);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL init_update_dropped_taken: got %b expected 0", pred_taken); end
    checks++;
    if (pred_target !== 32'h104) begin errors++; $display("[TB] FAIL init_update_dropped_target: got %h expected 00000104", pred_target); end
  endtask

  task automatic test_train();
    update(32'h100, 1'b1, 1'b0, 32'h80);
    fetch(32'h100);
    checks++;
    if (pred_valid !== 1'b1) begin errors++; $display("[TB] FAIL train_valid: got %b expected 1", pred_valid); end
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL train_taken: got %b expected 1", pred_taken); end
    checks++;
    if (pred_target !== 32'h80) begin errors++; $display("[TB] FAIL train_target: got %h expected 00000080", pred_target); end
    tick();
    checks++;
    if (pred_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid: got %b expected 0", pred_valid); end
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL idle_taken: got %b expected 0", pred_taken); end
    checks++;
    if (pred_target !== 32'h80) begin errors++; $display("[TB] FAIL idle_target_hold: got %h expected 00000080", pred_target); end
  endtask

  task automatic test_saturation();
    repeat (3) update(32'h100, 1'b1, 1'b0, 32'h80);
    update(32'h100, 1'b0, 1'b0, 32'h0);
    fetch(32'h100);
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL sat_st_to_wt_taken: got %b expected 1", pred_taken); end
    checks++;
    if (pred_target !== 32'h80) begin errors++; $display("[TB] FAIL sat_st_to_wt_target: got %h expected 00000080", pred_target); end
    update(32'h100, 1'b0, 1'b0, 32'h0);
    fetch(32'h100);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL sat_wt_to_wnt_taken: got %b expected 0", pred_taken); end
    checks++;
    if (pred_target !== 32'h104) begin errors++; $display("[TB] FAIL sat_wt_to_wnt_target: got %h expected 00000104", pred_target); end
  endtask

  task automatic test_aliasing();
    update(32'h100, 1'b1, 1'b0, 32'h80);
    fetch(32'h140);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL alias_tag_miss_taken: got %b expected 0", pred_taken); end
    checks++;
    if (pred_target !== 32'h144) begin errors++; $display("[TB] FAIL alias_tag_miss_target: got %h expected 00000144", pred_target); end
    update(32'h140, 1'b0, 1'b0, 32'h999);
    fetch(32'h100);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL alias_shared_ctr_taken: got %b expected 0", pred_taken); end
    checks++;
    if (pred_target !== 32'h104) begin errors++; $display("[TB] FAIL alias_shared_ctr_target: got %h expected 00000104", pred_target); end
    repeat (2) update(32'h100, 1'b1, 1'b0, 32'h80);
    update(32'h140, 1'b0, 1'b0, 32'h888);
    fetch(32'h100);
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL alias_btb_kept_taken: got %b expected 1", pred_taken); end
    checks++;
    if (pred_target !== 32'h80) begin errors++; $display("[TB] FAIL alias_btb_kept_target: got %h expected 00000080", pred_target); end
  endtask

  task automatic test_back_to_back();
    reset_and_init();
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_init_done: got %b expected 1", init_done); end
    fetch_valid = 1'b1;
    fetch_pc    = 32'h200;
    update(32'h200, 1'b1, 1'b0, 32'h40);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL b2b_read_first_taken: got %b expected 0", pred_taken); end
    checks++;
    if (pred_target !== 32'h204) begin errors++; $display("[TB] FAIL b2b_read_first_target: got %h expected 00000204", pred_target); end
    update(32'h200, 1'b1, 1'b0, 32'h40);
    fetch_valid = 1'b0;
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL b2b_next_sees_taken: got %b expected 1", pred_taken); end
    checks++;
    if (pred_target !== 32'h40) begin errors++; $display("[TB] FAIL b2b_next_sees_target: got %h expected 00000040", pred_target); end
    repeat (3) update(32'h200, 1'b0, 1'b0, 32'h0);
    update(32'h300, 1'b1, 1'b1, 32'h500);
    fetch(32'h300);
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL always_force_st_taken: got %b expected 1", pred_taken); end
    checks++;
    if (pred_target !== 32'h500) begin errors++; $display("[TB] FAIL always_force_st_target: got %h expected 00000500", pred_target); end
    fetch(32'hFFFF_FFFC);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL wrap_taken: got %b expected 0", pred_taken); end
    checks++;
    if (pred_target !== 32'h0) begin errors++; $display("[TB] FAIL wrap_target: got %h expected 00000000", pred_target); end
  endtask

  task automatic test_async_reset();
    repeat (2) update(32'h100, 1'b1, 1'b0, 32'h80);
    fetch_valid = 1'b1;
    fetch_pc    = 32'h100;
    tick();
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_taken: got %b expected 1", pred_taken); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (pred_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %b expected 0", pred_valid); end
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL areset_init_done: got %b expected 0", init_done); end
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL areset_taken: got %b expected 0", pred_taken); end
    fetch_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (16) tick();
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("[TB] FAIL areset_reinit_done: got %b expected 1", init_done); end
    fetch(32'h100);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL areset_cleared_taken: got %b expected 0", pred_taken); end
    checks++;
    if (pred_target !== 32'h104) begin errors++; $display("[TB] FAIL areset_cleared_target: got %h expected 00000104", pred_target); end
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_init();
    test_train();
    test_saturation();
    test_aliasing();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
